// File: rtl/merge_arbiter_pkg.sv
// merge_arbiter_pkg
//  Shared definitions for the two-lane merge stage: lane encodings used on
//  src_o, default widths shared with the 1:2 dispatch stage, and the
//  round-robin priority type used by the arbiter.
package merge_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    localparam logic LANE1 = 1'b0;
    localparam logic LANE2 = 1'b1;

    // Which lane wins when both request in the same cycle
    typedef enum logic {
        PRIO_L1 = 1'b0,
        PRIO_L2 = 1'b1
    } prio_e;

endpackage

// File: rtl/merge_arbiter_if.sv
// merge_arbiter_if
//  Bundles the two input lane streams, the merged output stream and the
//  grant-statistics signals of merge_arbiter.
//  slave  : merge_arbiter side (consumes lanes, drives output/stats)
//  master : environment side (drives lanes, stall_i, clr_cnt)
interface merge_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              v_i1;
    logic [DATA_W-1:0] data_i1;
    logic              stall_o1;
    logic              v_i2;
    logic [DATA_W-1:0] data_i2;
    logic              stall_o2;
    logic              v_o;
    logic [DATA_W-1:0] data_o;
    logic              src_o;
    logic              stall_i;
    logic              clr_cnt;
    logic [CNT_W-1:0]  cnt_o1;
    logic [CNT_W-1:0]  cnt_o2;

    modport slave (
        input  v_i1, data_i1, v_i2, data_i2, stall_i, clr_cnt,
        output stall_o1, stall_o2, v_o, data_o, src_o, cnt_o1, cnt_o2
    );

    modport master (
        output v_i1, data_i1, v_i2, data_i2, stall_i, clr_cnt,
        input  stall_o1, stall_o2, v_o, data_o, src_o, cnt_o1, cnt_o2
    );
endinterface

// File: rtl/merge_arbiter_rr_arb2.sv
// rr_arb2
//  Two-request round-robin arbiter. gnt is one-hot (or zero) and only
//  asserted while en=1. After a grant the other requester gets priority.
//  Ports: clk, reset (sync, active-high), req[1:0], en, gnt[1:0].
module rr_arb2
    import merge_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    prio_e      prio_r;
    logic [1:0] gnt_s;

    // Grant decode: single requester wins outright, contention goes to prio
    always_comb begin
        gnt_s = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = (prio_r == PRIO_L1) ? 2'b01 : 2'b10;
                default: gnt_s = 2'b00;
            endcase
        end else begin
            gnt_s = 2'b00;
        end
    end

    // Priority register: hand priority to the lane that was not just served
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_r <= PRIO_L1;
        end else if (gnt_s[0]) begin
            prio_r <= PRIO_L2;
        end else if (gnt_s[1]) begin
            prio_r <= PRIO_L1;
        end else begin
            prio_r <= prio_r;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/merge_arbiter.sv
// merge_arbiter
//  2:1 round-robin merge of the lane-1/lane-2 result streams onto a single
//  registered output stream, with saturating per-lane grant counters.
//  Ports: clk, reset (sync, active-high), bus (merge_arbiter_if.slave):
//   lane k: v_ik/data_ik in, stall_ok out (= lane k hold register full)
//   output: v_o/data_o/src_o registered, stall_i downstream backpressure
//   stats : clr_cnt in, cnt_o1/cnt_o2 grant counters
module merge_arbiter
    import merge_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
)(
    input  logic           clk,
    input  logic           reset,
    merge_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              hv1_r, hv2_r;
    logic [DATA_W-1:0] hd1_r, hd2_r;
    logic              v_r;
    logic [DATA_W-1:0] data_r;
    logic              src_r;
    logic [CNT_W-1:0]  cnt1_r, cnt2_r;

    logic              cand_v1_s, cand_v2_s;
    logic [DATA_W-1:0] cand_d1_s, cand_d2_s;
    logic              load_s;
    logic [1:0]        gnt_s;

    // Candidate per lane: a held word always beats the live input
    always_comb begin
        cand_v1_s = hv1_r | bus.v_i1;
        cand_v2_s = hv2_r | bus.v_i2;
        if (hv1_r) begin
            cand_d1_s = hd1_r;
        end else begin
            cand_d1_s = bus.data_i1;
        end
        if (hv2_r) begin
            cand_d2_s = hd2_r;
        end else begin
            cand_d2_s = bus.data_i2;
        end
        load_s = ~v_r | ~bus.stall_i;
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({cand_v2_s, cand_v1_s}),
        .en    (load_s),
        .gnt   (gnt_s)
    );

    // Output register: loads the granted word, goes empty when nothing granted
    always_ff @(posedge clk) begin
        if (reset) begin
            v_r    <= 1'b0;
            data_r <= {DATA_W{1'b0}};
            src_r  <= LANE1;
        end else if (load_s) begin
            if (gnt_s[0]) begin
                v_r    <= 1'b1;
                data_r <= cand_d1_s;
                src_r  <= LANE1;
            end else if (gnt_s[1]) begin
                v_r    <= 1'b1;
                data_r <= cand_d2_s;
                src_r  <= LANE2;
            end else begin
                v_r    <= 1'b0;
            end
        end else begin
            v_r    <= v_r;
        end
    end

    // Lane-1 hold: freed on grant, filled by an ungranted live word when empty
    always_ff @(posedge clk) begin
        if (reset) begin
            hv1_r <= 1'b0;
            hd1_r <= {DATA_W{1'b0}};
        end else if (gnt_s[0]) begin
            hv1_r <= 1'b0;
        end else if (!hv1_r && bus.v_i1) begin
            hv1_r <= 1'b1;
            hd1_r <= bus.data_i1;
        end else begin
            hv1_r <= hv1_r;
        end
    end

    // Lane-2 hold: same policy as lane 1
    always_ff @(posedge clk) begin
        if (reset) begin
            hv2_r <= 1'b0;
            hd2_r <= {DATA_W{1'b0}};
        end else if (gnt_s[1]) begin
            hv2_r <= 1'b0;
        end else if (!hv2_r && bus.v_i2) begin
            hv2_r <= 1'b1;
            hd2_r <= bus.data_i2;
        end else begin
            hv2_r <= hv2_r;
        end
    end

    // Grant counters: clear wins over a same-cycle grant, saturate at max
    always_ff @(posedge clk) begin
        if (reset || bus.clr_cnt) begin
            cnt1_r <= {CNT_W{1'b0}};
            cnt2_r <= {CNT_W{1'b0}};
        end else begin
            if (gnt_s[0] && (cnt1_r != CNT_MAX)) begin
                cnt1_r <= cnt1_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt1_r <= cnt1_r;
            end
            if (gnt_s[1] && (cnt2_r != CNT_MAX)) begin
                cnt2_r <= cnt2_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt2_r <= cnt2_r;
            end
        end
    end

    // Backpressure is the registered hold-full flag, so no path from stall_i
    assign bus.stall_o1 = hv1_r;
    assign bus.stall_o2 = hv2_r;
    assign bus.v_o      = v_r;
    assign bus.data_o   = data_r;
    assign bus.src_o    = src_r;
    assign bus.cnt_o1   = cnt1_r;
    assign bus.cnt_o2   = cnt2_r;

endmodule

// File: tb/tb_merge_arbiter.sv
// tb_merge_arbiter
//  Directed bench for merge_arbiter (CNT_W=4 so saturation is reachable).
//  Two lane sources advance when a valid word is not stalled; accepted
//  words go into per-lane expected queues, and every word consumed from the
//  output (v_o & ~stall_i at an edge) is matched against its lane's queue.
module tb_merge_arbiter;

    localparam int DW = 32;
    localparam int CW = 4;

    logic clk;
    logic reset;

    merge_arbiter_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    merge_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    logic          en1, en2;
    logic [DW-1:0] base1, base2, step1;
    int            idx1, idx2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive sources, sample pre-edge, update scoreboard after edge
    task automatic tick();
        logic acc1, acc2, cons, cs, rst_now;
        logic [DW-1:0] cd, w1, w2, e;
        w1 = base1 + step1 * 32'(idx1);
        w2 = base2 + 32'(idx2);
        bus.v_i1 = en1;
        bus.data_i1 = w1;
        bus.v_i2 = en2;
        bus.data_i2 = w2;
        #1;
        rst_now = reset;
        acc1 = en1 & ~bus.stall_o1;
        acc2 = en2 & ~bus.stall_o2;
        cons = bus.v_o & ~bus.stall_i;
        cd = bus.data_o;
        cs = bus.src_o;
        @(posedge clk);
        #1;
        if (rst_now) begin
            q1.delete();
            q2.delete();
        end else begin
            if (acc1) begin q1.push_back(w1); idx1++; end
            if (acc2) begin q2.push_back(w2); idx2++; end
            if (cons) begin
                if (cs == 1'b0) begin
                    check("sb_lane1_avail", 64'(q1.size() != 0), 64'd1);
                    if (q1.size() != 0) begin
                        e = q1.pop_front();
                        check("sb_lane1_data", 64'(cd), 64'(e));
                    end
                end else begin
                    check("sb_lane2_avail", 64'(q2.size() != 0), 64'd1);
                    if (q2.size() != 0) begin
                        e = q2.pop_front();
                        check("sb_lane2_data", 64'(cd), 64'(e));
                    end
                end
            end
        end
    endtask

    task automatic restart();
        reset = 1'b1;
        en1 = 1'b0;
        en2 = 1'b0;
        bus.stall_i = 1'b0;
        bus.clr_cnt = 1'b0;
        tick();
        reset = 1'b0;
        idx1 = 0;
        idx2 = 0;
    endtask

    initial begin
        logic [DW-1:0] e1;
        reset = 1'b1;
        en1 = 1'b0; en2 = 1'b0;
        base1 = 32'h0; base2 = 32'h0; step1 = 32'h1;
        idx1 = 0; idx2 = 0;
        bus.stall_i = 1'b0;
        bus.clr_cnt = 1'b0;
        tick();
        tick();
        check("rst_v_o",      64'(bus.v_o),      64'd0);
        check("rst_data_o",   64'(bus.data_o),   64'd0);
        check("rst_src_o",    64'(bus.src_o),    64'd0);
        check("rst_stall_o1", 64'(bus.stall_o1), 64'd0);
        check("rst_stall_o2", 64'(bus.stall_o2), 64'd0);
        check("rst_cnt_o1",   64'(bus.cnt_o1),   64'd0);
        check("rst_cnt_o2",   64'(bus.cnt_o2),   64'd0);
        reset = 1'b0;

        // Single lane: 0x11, 0x22, 0x33 appear one cycle later, in order
        base1 = 32'h0000_0011; step1 = 32'h0000_0011;
        en1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("single_v_o",     64'(bus.v_o),      64'd1);
            check("single_data",    64'(bus.data_o),   64'(32'h11 * (i + 1)));
            check("single_src",     64'(bus.src_o),    64'd0);
            check("single_stall_o1",64'(bus.stall_o1), 64'd0);
        end
        en1 = 1'b0;
        tick();
        check("single_idle_v_o", 64'(bus.v_o),    64'd0);
        check("single_cnt_o1",   64'(bus.cnt_o1), 64'd3);

        // Contention: strict alternation A0,B0,A1,B1,... with alternating stalls
        restart();
        base1 = 32'h0000_00A0; step1 = 32'h1; base2 = 32'h0000_00B0;
        en1 = 1'b1; en2 = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n % 2 == 1) begin
                check("cont_data", 64'(bus.data_o), 64'(32'hA0 + (n - 1) / 2));
                check("cont_src",  64'(bus.src_o),  64'd0);
                check("cont_s1",   64'(bus.stall_o1), 64'd0);
                check("cont_s2",   64'(bus.stall_o2), 64'd1);
            end else begin
                check("cont_data", 64'(bus.data_o), 64'(32'hB0 + (n - 2) / 2));
                check("cont_src",  64'(bus.src_o),  64'd1);
                check("cont_s1",   64'(bus.stall_o1), 64'd1);
                check("cont_s2",   64'(bus.stall_o2), 64'd0);
            end
        end
        check("cont_cnt_o1", 64'(bus.cnt_o1), 64'd5);
        check("cont_cnt_o2", 64'(bus.cnt_o2), 64'd5);

        // Reset mid-traffic: everything cleared, lane 1 wins first afterwards
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("mid_rst_v_o",  64'(bus.v_o),      64'd0);
        check("mid_rst_s1",   64'(bus.stall_o1), 64'd0);
        check("mid_rst_s2",   64'(bus.stall_o2), 64'd0);
        check("mid_rst_cnt1", 64'(bus.cnt_o1),   64'd0);
        check("mid_rst_cnt2", 64'(bus.cnt_o2),   64'd0);
        e1 = base1 + step1 * 32'(idx1);
        tick();
        check("mid_rst_prio_src",  64'(bus.src_o),  64'd0);
        check("mid_rst_prio_data", 64'(bus.data_o), 64'(e1));
        en1 = 1'b0; en2 = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // Backpressure: output frozen, both holds fill, drain in prio order
        restart();
        base1 = 32'h0000_00C0; step1 = 32'h1; base2 = 32'h0000_00D0;
        en1 = 1'b1; en2 = 1'b1;
        tick();
        check("bp_first", 64'(bus.data_o), 64'h0000_00C0);
        bus.stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_v_o",  64'(bus.v_o),      64'd1);
            check("bp_data", 64'(bus.data_o),   64'h0000_00C0);
            check("bp_s1",   64'(bus.stall_o1), 64'd1);
            check("bp_s2",   64'(bus.stall_o2), 64'd1);
        end
        en1 = 1'b0; en2 = 1'b0;
        bus.stall_i = 1'b0;
        tick();
        check("bp_drain1_data", 64'(bus.data_o), 64'h0000_00D0);
        check("bp_drain1_src",  64'(bus.src_o),  64'd1);
        tick();
        check("bp_drain2_data", 64'(bus.data_o), 64'h0000_00C1);
        check("bp_drain2_src",  64'(bus.src_o),  64'd0);
        tick();
        check("bp_drain_idle",  64'(bus.v_o),    64'd0);
        check("bp_drain_q1",    64'(q1.size()),  64'd0);
        check("bp_drain_q2",    64'(q2.size()),  64'd0);

        // Counter saturation on lane 2 and clear-with-grant
        restart();
        base2 = 32'h0000_0E00;
        en2 = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("cnt_14", 64'(bus.cnt_o2), 64'd14);
            if (i == 15) check("cnt_15", 64'(bus.cnt_o2), 64'd15);
            if (i == 16) check("cnt_sat16", 64'(bus.cnt_o2), 64'd15);
        end
        check("cnt_sat20", 64'(bus.cnt_o2), 64'd15);
        bus.clr_cnt = 1'b1;
        tick();
        bus.clr_cnt = 1'b0;
        check("clr_grant_v_o", 64'(bus.v_o),    64'd1);
        check("clr_cnt_o2",    64'(bus.cnt_o2), 64'd0);
        check("clr_cnt_o1",    64'(bus.cnt_o1), 64'd0);
        tick();
        check("post_clr_cnt_o2", 64'(bus.cnt_o2), 64'd1);
        en2 = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Random traffic against the per-lane scoreboard
        restart();
        base1 = 32'h1000_0000; step1 = 32'h1; base2 = 32'h2000_0000;
        for (int i = 0; i < 3000; i++) begin
            en1 = 1'($urandom_range(0, 1));
            en2 = 1'($urandom_range(0, 1));
            bus.stall_i = ($urandom_range(0, 3) == 0);
            tick();
        end
        en1 = 1'b0; en2 = 1'b0;
        bus.stall_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("rand_q1_empty", 64'(q1.size()), 64'd0);
        check("rand_q2_empty", 64'(q2.size()), 64'd0);
        check("rand_idle_v_o", 64'(bus.v_o),   64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
